// File: rtl/load_store_unit.sv
// Load/store unit: byte, halfword and word accesses onto a byte/word data memory; halfwords take two byte accesses.
// Latency 2 (byte/word), 3 (halfword), 1 (rejected); REQ_READY only in IDLE, so one request in flight at a time.
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RESP_VALID,
    output logic [31:0] RESP_RDATA,
    output logic        RESP_ERR,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    output logic        MEM_BYTE_RD,
    output logic        MEM_BYTE_WR,
    output logic        MEM_WRITE,
    output logic        MEM_EN,
    input  logic [31:0] MEM_RD
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} stateType;

    localparam logic [32:0] memLimit = 33'(MEM_BYTES);

    stateType    state, nextState;
    logic [31:0] addrQ, wdataQ, rdataQ;
    logic [1:0]  sizeQ;
    logic        weQ, signedQ, errQ;
    logic [2:0]  nBytes;
    logic [32:0] lastByte;
    logic        reqBad;

    // 33-bit last-byte address so a request wrapping past 2^32 still fails the range check
    always_comb begin
        case (REQ_SIZE)
            2'b00:   nBytes = 3'd1;
            2'b01:   nBytes = 3'd2;
            default: nBytes = 3'd4;
        endcase
        lastByte = {1'b0, REQ_ADDR} + 33'(nBytes) - 33'd1;
        reqBad   = (REQ_SIZE == 2'b11)
                 | ((REQ_SIZE == 2'b10) && (REQ_ADDR[1:0] != 2'b00))
                 | ((REQ_SIZE == 2'b01) && REQ_ADDR[0])
                 | (lastByte >= memLimit);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState   = state;
        REQ_READY   = 1'b0;
        RESP_VALID  = 1'b0;
        RESP_RDATA  = 32'd0;
        RESP_ERR    = 1'b0;
        MEM_A       = 32'd0;
        MEM_WD      = 32'd0;
        MEM_BYTE_RD = 1'b0;
        MEM_BYTE_WR = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_EN      = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = RST;
                if (REQ_VALID && RST) nextState = reqBad ? RESP : ACC0;
            end
            ACC0: begin
                MEM_EN    = 1'b1;
                MEM_A     = addrQ;
                MEM_WRITE = weQ;
                if (sizeQ == 2'b10) begin
                    MEM_WD = wdataQ;
                end else begin
                    MEM_BYTE_RD = 1'b1;
                    MEM_BYTE_WR = 1'b1;
                    MEM_WD      = {24'd0, wdataQ[7:0]};
                end
                nextState = (sizeQ == 2'b01) ? ACC1 : RESP;
            end
            ACC1: begin
                MEM_EN      = 1'b1;
                MEM_A       = addrQ + 32'd1;
                MEM_WRITE   = weQ;
                MEM_BYTE_RD = 1'b1;
                MEM_BYTE_WR = 1'b1;
                MEM_WD      = {24'd0, wdataQ[15:8]};
                nextState   = RESP;
            end
            RESP: begin
                RESP_VALID = 1'b1;
                RESP_RDATA = rdataQ;
                RESP_ERR   = errQ;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Halfword loads park the low byte in rdataQ[7:0] during ACC0 and extend from the high byte in ACC1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addrQ   <= 32'd0;
            wdataQ  <= 32'd0;
            rdataQ  <= 32'd0;
            sizeQ   <= 2'b00;
            weQ     <= 1'b0;
            signedQ <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        addrQ   <= REQ_ADDR;
                        wdataQ  <= REQ_WDATA;
                        sizeQ   <= REQ_SIZE;
                        weQ     <= REQ_WE;
                        signedQ <= REQ_SIGNED;
                        errQ    <= reqBad;
                        rdataQ  <= 32'd0;
                    end
                end
                ACC0: begin
                    if (!weQ) begin
                        case (sizeQ)
                            2'b10:   rdataQ <= MEM_RD;
                            2'b00:   rdataQ <= {{24{signedQ & MEM_RD[7]}}, MEM_RD[7:0]};
                            default: rdataQ <= {24'd0, MEM_RD[7:0]};
                        endcase
                    end
                end
                ACC1: begin
                    if (!weQ) rdataQ <= {{16{signedQ & MEM_RD[7]}}, MEM_RD[7:0], rdataQ[7:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, 128, number of addressable bytes in the downstream data memory; byte addresses 0..MEM_BYTES-1 are valid.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-low.
REQ-004 REQ_VALID  in  1  pipeline presents a memory request.
REQ-005 REQ_READY  out  1  unit can accept a request this cycle.
REQ-006 REQ_WE  in  1  1 = store, 0 = load.
REQ-007 REQ_SIZE  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 REQ_SIGNED  in  1  loads only: 1 sign-extends byte/halfword, 0 zero-extends.
REQ-009 REQ_ADDR  in  32  byte address.
REQ-010 REQ_WDATA  in  32  store data, little-endian, right-aligned.
REQ-011 RESP_VALID  out  1  one-cycle completion pulse.
REQ-012 RESP_RDATA  out  32  load result; 0 for stores and errors.
REQ-013 RESP_ERR  out  1  request rejected (misaligned, out of range, illegal size); valid with RESP_VALID.
REQ-014 MEM_A  out  32  data memory byte address.
REQ-015 MEM_WD  out  32  data memory write data.
REQ-016 MEM_BYTE_RD  out  1  data memory byte-read select (1 = byte, 0 = word).
REQ-017 MEM_BYTE_WR  out  1  data memory byte-write select (1 = byte, 0 = word).
REQ-018 MEM_WRITE  out  1  data memory write enable.
REQ-019 MEM_EN  out  1  data memory enable.
REQ-020 MEM_RD  in  32  data memory read data, combinational from MEM_A; byte reads return {24'b0, byte}.

Function
REQ-021 FSM states IDLE, ACC0, ACC1, RESP; REQ_READY SHALL be 1 only in IDLE.
REQ-022 Acceptance: REQ_VALID & REQ_READY at a rising edge; ADDR, WDATA, WE, SIZE, SIGNED latched into internal registers at that edge; request inputs ignored afterwards until IDLE.
REQ-023 Error check at acceptance: SIZE=11, word with ADDR[1:0]!=0, halfword with ADDR[0]!=0, or ADDR+bytes-1 >= MEM_BYTES -> next state RESP with error flag; no memory access issued.
REQ-024 Legal request: IDLE -> ACC0.
REQ-025 ACC0: MEM_EN=1, MEM_A=latched ADDR, MEM_WRITE=WE; word: MEM_BYTE_RD=MEM_BYTE_WR=0, MEM_WD=WDATA; byte/half: MEM_BYTE_RD=MEM_BYTE_WR=1, MEM_WD={24'b0,WDATA[7:0]}.
REQ-026 ACC0 -> RESP for byte/word; ACC0 -> ACC1 for halfword.
REQ-027 ACC1 (halfword only): MEM_EN=1, MEM_A=ADDR+1, byte selects=1, MEM_WD={24'b0,WDATA[15:8]}, MEM_WRITE=WE; ACC1 -> RESP.
REQ-028 Loads: MEM_RD sampled at end of ACC0 (and ACC1 for high byte of halfword) into a result register.
REQ-029 Load result: word = MEM_RD; byte = {24{s&b[7]}, b}; half = {16{s&h[15]}, h}, s = latched SIGNED.
REQ-030 RESP: RESP_VALID=1 for exactly one cycle, RESP_RDATA/RESP_ERR driven from registers; RESP -> IDLE.
REQ-031 Latency accept-edge to RESP_VALID high: byte/word 2 cycles, halfword 3, error 1; throughput one request per latency+1 cycles.
REQ-032 Outside ACC0/ACC1: MEM_EN=0, MEM_WRITE=0, MEM_A=0, MEM_WD=0, byte selects 0.
REQ-033 Outside RESP: RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0.
REQ-034 Address arithmetic modulo 2^32; range check performed in 33-bit width so wrap does not pass the check.

Reset
REQ-035 RST low asynchronously forces IDLE, clears latched request and result registers, all outputs to 0 except REQ_READY which becomes 1 after release.
REQ-036 Reset during ACC1 of a halfword store leaves the low byte written; no response issued; no rollback.
REQ-037 Request presented while RST low is not accepted.

Verification
REQ-038 Store word 0xDEADBEEF @0x10, then load word @0x10 -> RESP_RDATA=0xDEADBEEF, ERR=0, 2-cycle latency each.
REQ-039 Store byte 0x80 @0x05; load byte signed @0x05 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Store half 0x8001 @0x20; load half signed -> 0xFFFF8001, 3-cycle latency, MEM_A sequence 0x20, 0x21.
REQ-041 Load word @0x11 -> RESP_ERR=1, RDATA=0, MEM_EN never asserted, 1-cycle latency; word @0x7C ok, @0x80 error.
REQ-042 Assert RST low during ACC1 of half store 0xABCD @0x30 -> no RESP_VALID, REQ_READY=1 after release, byte 0x30 = 0xCD, byte 0x31 unchanged.
REQ-043 Back-to-back REQ_VALID held high -> REQ_READY low in ACC0/ACC1/RESP, second request accepted only in IDLE.
